// File: rtl/stdp_synapse_if.sv
// Spike inputs and learning outputs of one STDP synapse.
// master drives spikes and learn_en; slave (the synapse) returns weight and update pulses.
interface stdp_synapse_if #(
  parameter int unsigned WEIGHT_W = 8
);
  logic                pre_spike;
  logic                post_spike;
  logic                learn_en;
  logic [WEIGHT_W-1:0] weight;
  logic                ltp;
  logic                ltd;
  logic [3:0]          time_diff;

  modport master (
    output pre_spike, post_spike, learn_en,
    input  weight, ltp, ltd, time_diff
  );

  modport slave (
    input  pre_spike, post_spike, learn_en,
    output weight, ltp, ltd, time_diff
  );
endinterface

// File: rtl/stdp_synapse.sv
// Pair-based nearest-neighbour STDP synapse with saturating weight.
// Optional idle weight decay is compiled in with `define STDP_DECAY_EN.
module stdp_synapse #(
  parameter int unsigned WEIGHT_W     = 8,
  parameter int unsigned W_INIT       = 64,
  parameter int unsigned A_PLUS       = 8,
  parameter int unsigned A_MINUS      = 8,
  parameter int unsigned WINDOW       = 15,
  parameter int unsigned DECAY_PERIOD = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  stdp_synapse_if.slave bus
);

  // Two guard bits so weight + step can never wrap before saturation.
  localparam int unsigned CALC_W = WEIGHT_W + 2;
  localparam logic [CALC_W-1:0] W_MAX = {2'b00, {WEIGHT_W{1'b1}}};

  if (WINDOW < 1 || WINDOW > 15) begin : g_bad_window
    $error("stdp_synapse: WINDOW must be in 1..15");
  end
  if (DECAY_PERIOD < 1 || DECAY_PERIOD > 255) begin : g_bad_decay
    $error("stdp_synapse: DECAY_PERIOD must be in 1..255");
  end

  logic [WEIGHT_W-1:0] weight_q, weight_d;
  logic                ltp_q, ltp_d;
  logic                ltd_q, ltd_d;
  logic [3:0]          time_diff_q, time_diff_d;
  logic                pre_valid_q, pre_valid_d;
  logic [3:0]          pre_cnt_q, pre_cnt_d;
  logic                post_valid_q, post_valid_d;
  logic [3:0]          post_cnt_q, post_cnt_d;

  logic                do_ltp_c, do_ltd_c;
  logic [1:0]          pre_sh_c, post_sh_c;
  logic [CALC_W-1:0]   ltp_step_c, ltd_step_c, ltp_sum_c;

`ifdef STDP_DECAY_EN
  logic [7:0]          decay_cnt_q, decay_cnt_d;
`endif

  assign do_ltp_c = bus.post_spike && !bus.pre_spike && pre_valid_q && bus.learn_en;
  assign do_ltd_c = bus.pre_spike && !bus.post_spike && post_valid_q && bus.learn_en;

  // Step halves every 4 cycles of |dt|.
  assign pre_sh_c   = 2'((pre_cnt_q - 4'd1) >> 2);
  assign post_sh_c  = 2'((post_cnt_q - 4'd1) >> 2);
  assign ltp_step_c = CALC_W'(A_PLUS) >> pre_sh_c;
  assign ltd_step_c = CALC_W'(A_MINUS) >> post_sh_c;
  assign ltp_sum_c  = {2'b00, weight_q} + ltp_step_c;

  always_comb begin
    weight_d     = weight_q;
    ltp_d        = 1'b0;
    ltd_d        = 1'b0;
    time_diff_d  = time_diff_q;
    pre_valid_d  = pre_valid_q;
    pre_cnt_d    = pre_cnt_q;
    post_valid_d = post_valid_q;
    post_cnt_d   = post_cnt_q;

    if (bus.pre_spike) begin
      pre_valid_d = 1'b1;
      pre_cnt_d   = 4'd1;
    end else if (pre_valid_q) begin
      if (pre_cnt_q == 4'(WINDOW)) begin
        pre_valid_d = 1'b0;
        pre_cnt_d   = 4'd0;
      end else begin
        pre_cnt_d = pre_cnt_q + 4'd1;
      end
    end

    if (bus.post_spike) begin
      post_valid_d = 1'b1;
      post_cnt_d   = 4'd1;
    end else if (post_valid_q) begin
      if (post_cnt_q == 4'(WINDOW)) begin
        post_valid_d = 1'b0;
        post_cnt_d   = 4'd0;
      end else begin
        post_cnt_d = post_cnt_q + 4'd1;
      end
    end

    // A pairing consumes the partner trace so each spike pairs at most once.
    if (do_ltp_c) begin
      weight_d    = (ltp_sum_c > W_MAX) ? W_MAX[WEIGHT_W-1:0] : ltp_sum_c[WEIGHT_W-1:0];
      ltp_d       = 1'b1;
      time_diff_d = pre_cnt_q;
      pre_valid_d = 1'b0;
      pre_cnt_d   = 4'd0;
    end else if (do_ltd_c) begin
      weight_d     = (ltd_step_c > {2'b00, weight_q}) ? '0
                                                      : weight_q - ltd_step_c[WEIGHT_W-1:0];
      ltd_d        = 1'b1;
      time_diff_d  = post_cnt_q;
      post_valid_d = 1'b0;
      post_cnt_d   = 4'd0;
    end

    if (bus.pre_spike && bus.post_spike) begin
      pre_valid_d  = 1'b0;
      pre_cnt_d    = 4'd0;
      post_valid_d = 1'b0;
      post_cnt_d   = 4'd0;
    end

`ifdef STDP_DECAY_EN
    decay_cnt_d = decay_cnt_q;
    if (ltp_d || ltd_d) begin
      decay_cnt_d = 8'd0;
    end else if (decay_cnt_q == 8'(DECAY_PERIOD - 1)) begin
      decay_cnt_d = 8'd0;
      if (weight_q != '0) weight_d = weight_q - WEIGHT_W'(1);
    end else begin
      decay_cnt_d = decay_cnt_q + 8'd1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      weight_q     <= WEIGHT_W'(W_INIT);
      ltp_q        <= 1'b0;
      ltd_q        <= 1'b0;
      time_diff_q  <= 4'd0;
      pre_valid_q  <= 1'b0;
      pre_cnt_q    <= 4'd0;
      post_valid_q <= 1'b0;
      post_cnt_q   <= 4'd0;
    end else begin
      weight_q     <= weight_d;
      ltp_q        <= ltp_d;
      ltd_q        <= ltd_d;
      time_diff_q  <= time_diff_d;
      pre_valid_q  <= pre_valid_d;
      pre_cnt_q    <= pre_cnt_d;
      post_valid_q <= post_valid_d;
      post_cnt_q   <= post_cnt_d;
    end
  end

`ifdef STDP_DECAY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) decay_cnt_q <= 8'd0;
    else        decay_cnt_q <= decay_cnt_d;
  end
`endif

  assign bus.weight    = weight_q;
  assign bus.ltp       = ltp_q;
  assign bus.ltd       = ltd_q;
  assign bus.time_diff = time_diff_q;

endmodule

// File: tb/tb_stdp_synapse.sv
// Directed-vector bench for stdp_synapse (default parameters).
// Builds with or without STDP_DECAY_EN; the idle test adapts its expectation.
module tb_stdp_synapse;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  stdp_synapse_if #(.WEIGHT_W(8)) bus ();

  stdp_synapse #(
    .WEIGHT_W(8), .W_INIT(64), .A_PLUS(8), .A_MINUS(8), .WINDOW(15), .DECAY_PERIOD(255)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock cycle with the given spikes; outputs are valid on return.
  task automatic step(input logic pre, input logic post);
    bus.pre_spike  = pre;
    bus.post_spike = post;
    @(posedge clk);
    #1;
    bus.pre_spike  = 1'b0;
    bus.post_spike = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  // Pair then clear both traces with a coincident spike.
  task automatic pair_ltp(input int dt);
    step(1'b1, 1'b0);
    idle(dt - 1);
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
  endtask

  task automatic pair_ltd(input int dt);
    step(1'b0, 1'b1);
    idle(dt - 1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) step(1'(i % 2), 1'(1 - i % 2));
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.pre_spike  = 1'b0;
    bus.post_spike = 1'b0;
    bus.learn_en   = 1'b1;

    // Reset with spikes toggling
    do_reset();
    chk("rst_weight", int'(bus.weight), 64);
    chk("rst_ltp", int'(bus.ltp), 0);
    chk("rst_ltd", int'(bus.ltd), 0);
    chk("rst_tdiff", int'(bus.time_diff), 0);

    // LTP dt=2: 64 -> 72
    step(1'b1, 1'b0);
    idle(1);
    step(1'b0, 1'b1);
    chk("ltp2_weight", int'(bus.weight), 72);
    chk("ltp2_pulse", int'(bus.ltp), 1);
    chk("ltp2_noltd", int'(bus.ltd), 0);
    chk("ltp2_tdiff", int'(bus.time_diff), 2);
    step(1'b0, 1'b0);
    chk("ltp2_pulse_end", int'(bus.ltp), 0);
    chk("ltp2_tdiff_hold", int'(bus.time_diff), 2);
    step(1'b1, 1'b1);
    chk("coinc_weight", int'(bus.weight), 72);

    // Asynchronous reset between clock edges
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_weight", int'(bus.weight), 64);
    chk("async_rst_tdiff", int'(bus.time_diff), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // LTD dt=6: 64 -> 60; later pre does not re-pair
    step(1'b0, 1'b1);
    idle(5);
    step(1'b1, 1'b0);
    chk("ltd6_weight", int'(bus.weight), 60);
    chk("ltd6_pulse", int'(bus.ltd), 1);
    chk("ltd6_tdiff", int'(bus.time_diff), 6);
    step(1'b1, 1'b0);
    chk("ltd6_second_pre_weight", int'(bus.weight), 60);
    chk("ltd6_second_pre_ltd", int'(bus.ltd), 0);
    chk("ltd6_second_pre_tdiff", int'(bus.time_diff), 6);

    // Window expired at dt=16
    do_reset();
    step(1'b1, 1'b0);
    idle(15);
    step(1'b0, 1'b1);
    chk("expired_ltp", int'(bus.ltp), 0);
    chk("expired_weight", int'(bus.weight), 64);
    step(1'b1, 1'b1);

    // Window edge dt=15: step 8>>3 = 1
    step(1'b1, 1'b0);
    idle(14);
    step(1'b0, 1'b1);
    chk("dt15_weight", int'(bus.weight), 65);
    chk("dt15_tdiff", int'(bus.time_diff), 15);
    step(1'b1, 1'b1);

    // Coincident spikes clear pending pre trace
    step(1'b1, 1'b0);
    idle(1);
    step(1'b1, 1'b1);
    chk("coinc_noltp", int'(bus.ltp), 0);
    chk("coinc_noltd", int'(bus.ltd), 0);
    step(1'b0, 1'b1);
    chk("after_coinc_ltp", int'(bus.ltp), 0);
    chk("after_coinc_weight", int'(bus.weight), 65);
    step(1'b1, 1'b1);

    // Pending pre trace is dropped by reset
    step(1'b1, 1'b0);
    rst_n = 1'b0;
    step(1'b0, 1'b0);
    rst_n = 1'b1;
    step(1'b0, 1'b1);
    chk("rst_drop_ltp", int'(bus.ltp), 0);
    chk("rst_drop_weight", int'(bus.weight), 64);
    step(1'b1, 1'b1);

    // learn_en=0 holds weight and leaves the trace for a later pairing
    step(1'b1, 1'b0);
    bus.learn_en = 1'b0;
    step(1'b0, 1'b1);
    chk("nolearn_ltp", int'(bus.ltp), 0);
    chk("nolearn_weight", int'(bus.weight), 64);
    chk("nolearn_tdiff", int'(bus.time_diff), 0);
    bus.learn_en = 1'b1;
    step(1'b0, 1'b1);
    chk("relearn_ltp", int'(bus.ltp), 1);
    chk("relearn_weight", int'(bus.weight), 72);
    chk("relearn_tdiff", int'(bus.time_diff), 2);
    step(1'b1, 1'b1);

    // Upper saturation: 64 + 23*8 + 2 = 250, then +8 clips at 255
    do_reset();
    for (int i = 0; i < 23; i++) pair_ltp(1);
    pair_ltp(9);
    chk("climb_weight", int'(bus.weight), 250);
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    chk("sat_hi_weight", int'(bus.weight), 255);
    chk("sat_hi_ltp", int'(bus.ltp), 1);
    chk("sat_hi_tdiff", int'(bus.time_diff), 1);
    step(1'b1, 1'b1);

    // Lower saturation: 255 - 31*8 - 4 = 3, then -8 clips at 0
    for (int i = 0; i < 31; i++) pair_ltd(1);
    pair_ltd(5);
    chk("descend_weight", int'(bus.weight), 3);
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    chk("sat_lo_weight", int'(bus.weight), 0);
    chk("sat_lo_ltd", int'(bus.ltd), 1);
    step(1'b1, 1'b1);

    // Idle behaviour
    do_reset();
`ifdef STDP_DECAY_EN
    idle(254);
    chk("decay_before", int'(bus.weight), 64);
    idle(1);
    chk("decay_step", int'(bus.weight), 63);
`else
    idle(1000);
    chk("idle_hold_weight", int'(bus.weight), 64);
    chk("idle_hold_ltp", int'(bus.ltp), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
